// File: rtl/selfcomp_pkg.sv
// Shared encodings and default widths for the self-composition leak monitor.
package selfcomp_pkg;

  localparam int DEF_DATA_W   = 128;
  localparam int DEF_SKEW_W   = 8;
  localparam int DEF_MAX_SKEW = 0;
  localparam int DEF_TIMEOUT  = 200;
  localparam int DEF_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPORT = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  typedef enum logic {
    SIDE_ONE = 1'b0,
    SIDE_TWO = 1'b1
  } side_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous load; sat=1 holds at all-ones, sat=0 wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic         sat,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !(sat && (&cnt))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/selfcomp_leak_monitor.sv
// Pairs the two SE output streams, measures arrival skew, flags timing leaks
// and result divergence, and keeps sticky/cumulative statistics.
module selfcomp_leak_monitor
  import selfcomp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SKEW_W   = DEF_SKEW_W,
  parameter int MAX_SKEW = DEF_MAX_SKEW,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_validOne,
  input  logic              io_in_validTwo,
  input  logic [DATA_W-1:0] io_in_resultOne,
  input  logic [DATA_W-1:0] io_in_resultTwo,
  output logic              io_in_ready,
  output logic              io_rpt_valid,
  output logic [SKEW_W-1:0] io_rpt_skew,
  output logic              io_rpt_timingLeak,
  output logic              io_rpt_mismatch,
  output logic [CNT_W-1:0]  io_txnCount,
  output logic [CNT_W-1:0]  io_leakCount,
  output logic              io_stickyLeak,
  output logic              io_timeout,
  output logic              io_protoErr
);

  state_e              state;
  side_e               side;
  logic [SKEW_W-1:0]   skew;
  logic                skew_en;
  logic                skew_load;
  logic [SKEW_W-1:0]   skew_load_val;
  logic                results_differ;
  logic                first_valid;
  logic                other_valid;
  logic                skew_at_timeout;
  logic                in_report;
  logic                rpt_bad;

  function automatic logic is_leak(input logic [SKEW_W-1:0] s);
    return 32'(s) > 32'(MAX_SKEW);
  endfunction

  assign results_differ  = io_in_resultOne != io_in_resultTwo;
  assign first_valid     = (side == SIDE_ONE) ? io_in_validOne : io_in_validTwo;
  assign other_valid     = (side == SIDE_ONE) ? io_in_validTwo : io_in_validOne;
  assign skew_at_timeout = skew == SKEW_W'(TIMEOUT);
  assign in_report       = state == ST_REPORT;
  assign rpt_bad         = in_report && (io_rpt_timingLeak || io_rpt_mismatch);

  // Skew restarts on the first arrival: 0 for simultaneous, 1 when one copy leads.
  always_comb begin
    skew_en       = 1'b0;
    skew_load     = 1'b0;
    skew_load_val = '0;
    case (state)
      ST_IDLE: begin
        if (io_in_validOne || io_in_validTwo) begin
          skew_load     = 1'b1;
          skew_load_val = (io_in_validOne && io_in_validTwo) ? '0 : SKEW_W'(1);
        end
      end
      ST_WAIT: skew_en = !other_valid && !skew_at_timeout;
      default: ;
    endcase
  end

  sat_counter #(.W(SKEW_W)) u_skew (
    .clock(clock), .reset(reset), .en(skew_en), .load(skew_load),
    .sat(1'b1), .load_val(skew_load_val), .cnt(skew)
  );

  sat_counter #(.W(CNT_W)) u_txn (
    .clock(clock), .reset(reset), .en(in_report), .load(1'b0),
    .sat(1'b0), .load_val('0), .cnt(io_txnCount)
  );

  sat_counter #(.W(CNT_W)) u_leak (
    .clock(clock), .reset(reset), .en(rpt_bad), .load(1'b0),
    .sat(1'b1), .load_val('0), .cnt(io_leakCount)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= ST_IDLE;
      side              <= SIDE_ONE;
      io_in_ready       <= 1'b0;
      io_rpt_valid      <= 1'b0;
      io_rpt_skew       <= '0;
      io_rpt_timingLeak <= 1'b0;
      io_rpt_mismatch   <= 1'b0;
      io_stickyLeak     <= 1'b0;
      io_timeout        <= 1'b0;
      io_protoErr       <= 1'b0;
    end else begin
      io_in_ready  <= 1'b0;
      io_rpt_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (io_in_validOne && io_in_validTwo) begin
            state             <= ST_REPORT;
            io_in_ready       <= 1'b1;
            io_rpt_valid      <= 1'b1;
            io_rpt_skew       <= '0;
            io_rpt_timingLeak <= is_leak('0);
            io_rpt_mismatch   <= results_differ;
          end else if (io_in_validOne || io_in_validTwo) begin
            side  <= io_in_validOne ? SIDE_ONE : SIDE_TWO;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A leading copy that withdraws its valid broke the handshake contract.
          if (!first_valid) io_protoErr <= 1'b1;
          if (other_valid) begin
            state             <= ST_REPORT;
            io_in_ready       <= 1'b1;
            io_rpt_valid      <= 1'b1;
            io_rpt_skew       <= skew;
            io_rpt_timingLeak <= is_leak(skew);
            io_rpt_mismatch   <= results_differ;
          end else if (skew_at_timeout) begin
            io_timeout <= 1'b1;
            state      <= ST_HALT;
          end
        end
        ST_REPORT: begin
          state <= ST_IDLE;
          if (io_rpt_timingLeak || io_rpt_mismatch) io_stickyLeak <= 1'b1;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_selfcomp_leak_monitor.sv
// Directed bench for selfcomp_leak_monitor with hand-computed expectations.
module tb_selfcomp_leak_monitor;

  localparam int DATA_W   = 128;
  localparam int SKEW_W   = 8;
  localparam int MAX_SKEW = 0;
  localparam int TIMEOUT  = 4;
  localparam int CNT_W    = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              validOne = 1'b0;
  logic              validTwo = 1'b0;
  logic [DATA_W-1:0] resultOne = '0;
  logic [DATA_W-1:0] resultTwo = '0;
  logic              ready;
  logic              rpt_valid;
  logic [SKEW_W-1:0] rpt_skew;
  logic              rpt_timingLeak;
  logic              rpt_mismatch;
  logic [CNT_W-1:0]  txnCount;
  logic [CNT_W-1:0]  leakCount;
  logic              stickyLeak;
  logic              timeout;
  logic              protoErr;

  int n_checks = 0;
  int n_fail   = 0;

  selfcomp_leak_monitor #(
    .DATA_W(DATA_W), .SKEW_W(SKEW_W), .MAX_SKEW(MAX_SKEW),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .io_in_validOne(validOne), .io_in_validTwo(validTwo),
    .io_in_resultOne(resultOne), .io_in_resultTwo(resultTwo),
    .io_in_ready(ready), .io_rpt_valid(rpt_valid), .io_rpt_skew(rpt_skew),
    .io_rpt_timingLeak(rpt_timingLeak), .io_rpt_mismatch(rpt_mismatch),
    .io_txnCount(txnCount), .io_leakCount(leakCount),
    .io_stickyLeak(stickyLeak), .io_timeout(timeout), .io_protoErr(protoErr)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; validOne = 1'b0; validTwo = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({ready, rpt_valid, rpt_timingLeak, rpt_mismatch} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {ready, rpt_valid, rpt_timingLeak, rpt_mismatch}); end
    n_checks++; if (rpt_skew !== '0) begin n_fail++; $display("FAIL reset_skew: got %0d expected 0", rpt_skew); end
    n_checks++; if (txnCount !== '0 || leakCount !== '0) begin n_fail++; $display("FAIL reset_counts: got txn=%0d leak=%0d expected 0/0", txnCount, leakCount); end
    n_checks++; if ({stickyLeak, timeout, protoErr} !== 3'b0) begin n_fail++; $display("FAIL reset_sticky: got %b expected 000", {stickyLeak, timeout, protoErr}); end
  endtask

  task automatic test_clean();
    do_reset();
    resultOne = 128'h5; resultTwo = 128'h5; validOne = 1'b1; validTwo = 1'b1;
    tick();
    n_checks++; if (ready !== 1'b1 || rpt_valid !== 1'b1) begin n_fail++; $display("FAIL clean_handshake: got ready=%b rpt=%b expected 1/1", ready, rpt_valid); end
    n_checks++; if (rpt_skew !== 8'd0) begin n_fail++; $display("FAIL clean_skew: got %0d expected 0", rpt_skew); end
    n_checks++; if (rpt_timingLeak !== 1'b0 || rpt_mismatch !== 1'b0) begin n_fail++; $display("FAIL clean_flags: got leak=%b mm=%b expected 0/0", rpt_timingLeak, rpt_mismatch); end
    tick();
    validOne = 1'b0; validTwo = 1'b0;
    n_checks++; if (ready !== 1'b0 || rpt_valid !== 1'b0) begin n_fail++; $display("FAIL clean_pulse_end: got ready=%b rpt=%b expected 0/0", ready, rpt_valid); end
    n_checks++; if (txnCount !== 4'd1 || leakCount !== 4'd0) begin n_fail++; $display("FAIL clean_counts: got txn=%0d leak=%0d expected 1/0", txnCount, leakCount); end
    n_checks++; if (stickyLeak !== 1'b0) begin n_fail++; $display("FAIL clean_sticky: got %b expected 0", stickyLeak); end
  endtask

  task automatic test_skew_leak();
    do_reset();
    resultOne = 128'h7; resultTwo = 128'h7; validOne = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) validTwo = 1'b1;
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL skew_ready_early: cycle t+%0d got %b expected 0", k, ready); end
    end
    tick();
    n_checks++; if (ready !== 1'b1 || rpt_valid !== 1'b1) begin n_fail++; $display("FAIL skew_handshake: got ready=%b rpt=%b expected 1/1", ready, rpt_valid); end
    n_checks++; if (rpt_skew !== 8'd3) begin n_fail++; $display("FAIL skew_value: got %0d expected 3", rpt_skew); end
    n_checks++; if (rpt_timingLeak !== 1'b1 || rpt_mismatch !== 1'b0) begin n_fail++; $display("FAIL skew_flags: got leak=%b mm=%b expected 1/0", rpt_timingLeak, rpt_mismatch); end
    tick();
    validOne = 1'b0; validTwo = 1'b0;
    n_checks++; if (stickyLeak !== 1'b1 || leakCount !== 4'd1 || txnCount !== 4'd1) begin n_fail++; $display("FAIL skew_stats: got sticky=%b leak=%0d txn=%0d expected 1/1/1", stickyLeak, leakCount, txnCount); end
    n_checks++; if (protoErr !== 1'b0) begin n_fail++; $display("FAIL skew_proto: got %b expected 0", protoErr); end
    tick();
    n_checks++; if (rpt_skew !== 8'd3 || rpt_timingLeak !== 1'b1) begin n_fail++; $display("FAIL skew_hold: got skew=%0d leak=%b expected 3/1", rpt_skew, rpt_timingLeak); end
  endtask

  task automatic test_mismatch();
    do_reset();
    resultOne = 128'h1; resultTwo = 128'h2; validOne = 1'b1; validTwo = 1'b1;
    tick();
    n_checks++; if (rpt_mismatch !== 1'b1 || rpt_timingLeak !== 1'b0) begin n_fail++; $display("FAIL mm_flags: got mm=%b leak=%b expected 1/0", rpt_mismatch, rpt_timingLeak); end
    tick();
    validOne = 1'b0; validTwo = 1'b0;
    n_checks++; if (leakCount !== 4'd1 || stickyLeak !== 1'b1) begin n_fail++; $display("FAIL mm_stats: got leak=%0d sticky=%b expected 1/1", leakCount, stickyLeak); end
    // Top-bit-only difference exercises the full-width compare.
    resultOne = {1'b1, 127'h0}; resultTwo = '0; validOne = 1'b1; validTwo = 1'b1;
    tick();
    n_checks++; if (rpt_mismatch !== 1'b1) begin n_fail++; $display("FAIL mm_msb: got %b expected 1", rpt_mismatch); end
    tick();
    validOne = 1'b0; validTwo = 1'b0;
    n_checks++; if (leakCount !== 4'd2 || txnCount !== 4'd2) begin n_fail++; $display("FAIL mm_stats2: got leak=%0d txn=%0d expected 2/2", leakCount, txnCount); end
  endtask

  task automatic test_timeout();
    do_reset();
    resultOne = 128'h3; resultTwo = 128'h3; validTwo = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++; if (timeout !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL to_early: cycle t+%0d got to=%b ready=%b expected 0/0", k, timeout, ready); end
    end
    tick();
    n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_set: got %b expected 1", timeout); end
    validOne = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++; if (ready !== 1'b0 || rpt_valid !== 1'b0 || timeout !== 1'b1) begin n_fail++; $display("FAIL to_halt: got ready=%b rpt=%b to=%b expected 0/0/1", ready, rpt_valid, timeout); end
    end
    n_checks++; if (protoErr !== 1'b0 || txnCount !== 4'd0) begin n_fail++; $display("FAIL to_side: got proto=%b txn=%0d expected 0/0", protoErr, txnCount); end
    do_reset();
    n_checks++; if ({ready, rpt_valid, stickyLeak, timeout, protoErr} !== 5'b0) begin n_fail++; $display("FAIL to_reset: got %b expected 00000", {ready, rpt_valid, stickyLeak, timeout, protoErr}); end
    validOne = 1'b1; validTwo = 1'b1;
    tick();
    n_checks++; if (rpt_valid !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL to_resume: got rpt=%b ready=%b expected 1/1", rpt_valid, ready); end
    tick();
    validOne = 1'b0; validTwo = 1'b0;
  endtask

  task automatic test_proto_err();
    do_reset();
    resultOne = 128'h9; resultTwo = 128'h9; validOne = 1'b1;
    tick();
    validOne = 1'b0;
    tick();
    n_checks++; if (protoErr !== 1'b1) begin n_fail++; $display("FAIL proto_set: got %b expected 1", protoErr); end
    validTwo = 1'b1;
    tick();
    n_checks++; if (rpt_valid !== 1'b1 || rpt_skew !== 8'd2) begin n_fail++; $display("FAIL proto_report: got rpt=%b skew=%0d expected 1/2", rpt_valid, rpt_skew); end
    tick();
    validTwo = 1'b0;
    n_checks++; if (txnCount !== 4'd1 || protoErr !== 1'b1) begin n_fail++; $display("FAIL proto_after: got txn=%0d proto=%b expected 1/1", txnCount, protoErr); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    resultOne = 128'h4; resultTwo = 128'h4; validOne = 1'b1;
    tick(); tick();
    reset = 1'b1; validOne = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick();
    n_checks++; if (txnCount !== 4'd0 || ready !== 1'b0 || rpt_valid !== 1'b0 || protoErr !== 1'b0) begin n_fail++; $display("FAIL midflight: got txn=%0d ready=%b rpt=%b proto=%b expected 0/0/0/0", txnCount, ready, rpt_valid, protoErr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    resultOne = 128'hA; resultTwo = 128'hA; validOne = 1'b1; validTwo = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      n_checks++; if (rpt_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rpt: txn %0d got %b expected 1", i, rpt_valid); end
      tick();
      n_checks++; if (rpt_valid !== 1'b0 || txnCount !== 4'((i + 1) % 16)) begin n_fail++; $display("FAIL b2b_txn: txn %0d got rpt=%b txn=%0d expected 0/%0d", i, rpt_valid, txnCount, (i + 1) % 16); end
    end
    validOne = 1'b0; validTwo = 1'b0;
    n_checks++; if (leakCount !== 4'd0 || stickyLeak !== 1'b0) begin n_fail++; $display("FAIL b2b_clean: got leak=%0d sticky=%b expected 0/0", leakCount, stickyLeak); end
  endtask

  task automatic test_leak_saturate();
    do_reset();
    resultOne = 128'h1; resultTwo = 128'h2; validOne = 1'b1; validTwo = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick(); tick();
      n_checks++; if (leakCount !== 4'((i + 1 > 15) ? 15 : i + 1)) begin n_fail++; $display("FAIL sat_leak: txn %0d got %0d expected %0d", i, leakCount, (i + 1 > 15) ? 15 : i + 1); end
    end
    validOne = 1'b0; validTwo = 1'b0;
    n_checks++; if (txnCount !== 4'd1 || stickyLeak !== 1'b1) begin n_fail++; $display("FAIL sat_txn: got txn=%0d sticky=%b expected 1/1", txnCount, stickyLeak); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_skew_leak();
    test_mismatch();
    test_timeout();
    test_proto_err();
    test_reset_midflight();
    test_back_to_back();
    test_leak_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/selfcomp_leak_monitor.md
# selfcomp_leak_monitor

Downstream consumer of the self-composition tester. It takes the two SE output streams (`validOne`/`resultOne` and `validTwo`/`resultTwo`) and closes the shared `io_out_ready` handshake. For every transaction it measures the arrival skew between the two copies and flags timing leaks and result divergence. It keeps sticky and cumulative statistics for the formal/sim harness.

## Interface
Parameters:
- `DATA_W`, 128, result width.
- `SKEW_W`, 8, skew counter width; the counter saturates at 2^SKEW_W-1.
- `MAX_SKEW`, 0, tolerated skew in cycles; anything larger is a timing leak.
- `TIMEOUT`, 200, maximum cycles to wait for the second copy. Must satisfy 1 ≤ TIMEOUT ≤ 2^SKEW_W-1.
- `CNT_W`, 16, statistics counter width.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `io_in_validOne` in 1: valid from copy one.
- `io_in_validTwo` in 1: valid from copy two.
- `io_in_resultOne` in DATA_W: result from copy one.
- `io_in_resultTwo` in DATA_W: result from copy two.
- `io_in_ready` out 1: shared ready to both copies; drives the tester's `io_out_ready`.
- `io_rpt_valid` out 1: one-cycle report pulse.
- `io_rpt_skew` out SKEW_W: skew of the reported transaction.
- `io_rpt_timingLeak` out 1: reported skew > MAX_SKEW.
- `io_rpt_mismatch` out 1: resultOne != resultTwo.
- `io_txnCount` out CNT_W: completed transactions; wraps.
- `io_leakCount` out CNT_W: transactions with a timing leak or mismatch; saturates.
- `io_stickyLeak` out 1: set on any leak or mismatch.
- `io_timeout` out 1: sticky; the monitor is halted.
- `io_protoErr` out 1: sticky; the first valid dropped before the handshake.

## Operation
States: IDLE, WAIT, REPORT, HALT.
- **IDLE**
  - Both valids high: capture skew=0 and mismatch=(resultOne!=resultTwo); go to REPORT.
  - Exactly one valid high: latch `side` (which copy arrived first) and load skew=1; go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT**
  - The other copy's valid high: capture current skew and the mismatch compare; go to REPORT.
  - Else if skew == TIMEOUT: set `io_timeout`; go to HALT.
  - Else increment skew, saturating.
  - The latched side's valid low at any cycle in WAIT: set `io_protoErr`. Counting continues; the side latch is unchanged.
- **REPORT**
  - `io_in_ready`=1 and `io_rpt_valid`=1 for exactly one cycle; both copies are consumed.
  - `io_txnCount`+1 (wraps).
  - If timingLeak or mismatch: `io_leakCount`+1 (saturating) and set `io_stickyLeak`.
  - Always go to IDLE.
- **HALT**
  - `io_in_ready`=0 permanently; nothing is consumed.
  - Only `reset` exits HALT.
- `io_in_ready` is high only in REPORT. The monitor never pops one copy alone.
- Mismatch uses a full DATA_W equality compare, registered at the transition into REPORT. SE copies hold their results while valid and not ready, so the captured values are stable.

## Timing
- All outputs reset to 0; state resets to IDLE; skew and side reset to 0.
- Both valid at cycle t in IDLE: REPORT at t+1 (ready and rpt_valid high), counters updated at t+2, IDLE at t+2. Next transaction can be accepted at t+2.
- First valid at t, second at t+k (1≤k≤TIMEOUT): rpt_skew=k, REPORT at t+k+1.
- Second valid never arrives: skew reaches TIMEOUT at t+TIMEOUT; `io_timeout` high from t+TIMEOUT+1.
- `io_rpt_*` fields hold their last values outside REPORT; only `io_rpt_valid` pulses.
- Reset mid-WAIT or mid-REPORT: the in-flight transaction is dropped, no counter update, all sticky flags clear.
- `io_leakCount` at max stays at max; `io_txnCount` at max wraps to 0.

## Structure
- `selfcomp_pkg`: state encoding (IDLE/WAIT/REPORT/HALT), side encoding (ONE/TWO), default widths.
- One sub-module, `sat_counter` (parameterised width, enable, load, saturate/wrap select). Used for skew and both statistics counters.
- Top-level holds the FSM, side latch, mismatch register, and sticky flags.

## Test plan
- Both valid at t, equal results 0x5 → rpt_valid at t+1, skew=0, timingLeak=0, mismatch=0, txnCount=1, leakCount=0.
- validOne at t, validTwo at t+3, MAX_SKEW=0 → skew=3, timingLeak=1, stickyLeak=1, leakCount=1; ready high only at t+4.
- Both valid, resultOne=0x1, resultTwo=0x2 → mismatch=1, timingLeak=0, leakCount=1.
- validTwo only, TIMEOUT=4 → timeout=1 at t+5, ready stays 0 forever; reset → all outputs 0, IDLE resumes.
- validOne at t, dropped at t+1, validTwo at t+2 → protoErr=1, report skew=2.
- 2^CNT_W+1 back-to-back clean transactions (CNT_W=4) → txnCount wraps to 1; leak run of 17 → leakCount=15.
